// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared types and constants for the PE array sequencer
package pe_array_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        READ,
        DONE
    } state_t;

    localparam int ARR_N  = 4;
    localparam int DW_DEF = 8;
    localparam int RW_DEF = 32;

    // Cycles for the last operand beat to reach the far-corner sum:
    // (n-1) input skew stages, (n-1) PE hops, one sum register.
    function automatic int flush_cycles(input int n);
        return 2 * (n - 1) + 1;
    endfunction

    localparam int FLUSH_CYCLES_DEF = flush_cycles(ARR_N);

endpackage

// File: rtl/pe_array_seq_cnt.sv
// rtl/pe_array_seq_cnt.sv - loadable up-counter with enable and terminal-count flag
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   load      load count with load_val (has priority over en)
//   en        increment by one
//   term      terminal value compared against count
//   count     current value
//   tc        count == term
module pe_array_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/pe_array_seq.sv
// rtl/pe_array_seq.sv - job sequencer for the 4x4 output-stationary systolic PE array
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, cfg_k              job request (IDLE only) and operand beat count
//   busy, done                job in progress, one-cycle completion pulse
//   op_valid/op_ready/op_a/op_b  operand beat stream (A column k, B row k)
//   arr_rst_n, arr_en         array accumulator clear and global enable
//   arr_data0..3, arr_weight0..3  array row/column operand inputs
//   arr_out_sel, arr_result   array readout mux select and selected sum
//   res_valid/res_ready/res_data/res_idx/res_last  result stream, 16 beats
module pe_array_seq
    import pe_array_pkg::*;
#(
    parameter int KW           = 8,
    parameter int DW           = DW_DEF,
    parameter int RW           = RW_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KW-1:0]       cfg_k,
    output logic                busy,
    output logic                done,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [ARR_N*DW-1:0] op_a,
    input  logic [ARR_N*DW-1:0] op_b,
    output logic                arr_rst_n,
    output logic                arr_en,
    output logic [DW-1:0]       arr_data0,
    output logic [DW-1:0]       arr_data1,
    output logic [DW-1:0]       arr_data2,
    output logic [DW-1:0]       arr_data3,
    output logic [DW-1:0]       arr_weight0,
    output logic [DW-1:0]       arr_weight1,
    output logic [DW-1:0]       arr_weight2,
    output logic [DW-1:0]       arr_weight3,
    output logic [3:0]          arr_out_sel,
    input  logic [RW-1:0]       arr_result,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [RW-1:0]       res_data,
    output logic [3:0]          res_idx,
    output logic                res_last
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    state_t              state, state_nxt;
    logic [KW-1:0]       k_lat;
    logic [KW-1:0]       beat_cnt;
    logic                beat_tc;
    logic [FW-1:0]       flush_cnt;
    logic                flush_tc;
    logic [3:0]          rd_cnt;
    logic                rd_tc;
    logic [ARR_N*DW-1:0] feed_a, feed_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k_lat <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                k_lat <= cfg_k;
            end
        end
    end

    // Beat counter: terminal at k-1 so the k-th handshake ends FEED.
    // FEED is only entered with k != 0, so k-1 never underflows in use.
    pe_array_seq_cnt #(.W(KW)) u_beat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == CLEAR),
        .load_val ('0),
        .en       (state == FEED && op_valid),
        .term     (k_lat - KW'(1)),
        .count    (beat_cnt),
        .tc       (beat_tc)
    );

    pe_array_seq_cnt #(.W(FW)) u_flush_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state != FLUSH),
        .load_val ('0),
        .en       (state == FLUSH),
        .term     (FW'(FLUSH_CYCLES - 1)),
        .count    (flush_cnt),
        .tc       (flush_tc)
    );

    // Read counter is held at zero outside READ, so the select idles at 0.
    pe_array_seq_cnt #(.W(4)) u_rd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state != READ),
        .load_val ('0),
        .en       (state == READ && res_ready),
        .term     (4'd15),
        .count    (rd_cnt),
        .tc       (rd_tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = (k_lat != '0) ? FEED : FLUSH;
            FEED:    if (op_valid && beat_tc) state_nxt = FLUSH;
            FLUSH:   if (flush_tc) state_nxt = READ;
            READ:    if (res_ready && rd_tc) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        op_ready  = 1'b0;
        arr_en    = 1'b0;
        res_valid = 1'b0;
        feed_a    = '0;
        feed_b    = '0;
        case (state)
            CLEAR: busy = 1'b1;
            FEED: begin
                busy     = 1'b1;
                op_ready = 1'b1;
                // A stall freezes the whole array, keeping the skew aligned.
                arr_en   = op_valid;
                if (op_valid) begin
                    feed_a = op_a;
                    feed_b = op_b;
                end
            end
            FLUSH: begin
                busy   = 1'b1;
                arr_en = 1'b1;
            end
            READ: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Clear is combinational so reset wipes the array in the same cycle.
    assign arr_rst_n   = ~(rst | (state == CLEAR));

    assign arr_data0   = feed_a[0*DW +: DW];
    assign arr_data1   = feed_a[1*DW +: DW];
    assign arr_data2   = feed_a[2*DW +: DW];
    assign arr_data3   = feed_a[3*DW +: DW];
    assign arr_weight0 = feed_b[0*DW +: DW];
    assign arr_weight1 = feed_b[1*DW +: DW];
    assign arr_weight2 = feed_b[2*DW +: DW];
    assign arr_weight3 = feed_b[3*DW +: DW];

    assign arr_out_sel = rd_cnt;
    assign res_idx     = rd_cnt;
    assign res_data    = arr_result;
    assign res_last    = (state == READ) && (rd_cnt == 4'd15);

endmodule

// File: tb/tb_pe_array_seq.sv
// tb/tb_pe_array_seq.sv - randomized scoreboard bench for pe_array_seq with a systolic array model
module tb_pe_array_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_k;
    logic        busy, done;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b;
    logic        arr_rst_n, arr_en;
    logic [7:0]  arr_data0, arr_data1, arr_data2, arr_data3;
    logic [7:0]  arr_weight0, arr_weight1, arr_weight2, arr_weight3;
    logic [3:0]  arr_out_sel;
    logic [31:0] arr_result;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_idx;
    logic        res_last;

    pe_array_seq #(.KW(8), .DW(8), .RW(32), .FLUSH_CYCLES(7)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k),
        .busy(busy), .done(done),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .arr_rst_n(arr_rst_n), .arr_en(arr_en),
        .arr_data0(arr_data0), .arr_data1(arr_data1),
        .arr_data2(arr_data2), .arr_data3(arr_data3),
        .arr_weight0(arr_weight0), .arr_weight1(arr_weight1),
        .arr_weight2(arr_weight2), .arr_weight3(arr_weight3),
        .arr_out_sel(arr_out_sel), .arr_result(arr_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .res_last(res_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 4x4 output-stationary systolic array model ----------------
    logic [7:0]  din[4], win[4];
    logic [7:0]  ska[4][3], skb[4][3];
    logic [7:0]  pa[4][4], pb[4][4];
    logic [31:0] acc[4][4];

    assign din[0] = arr_data0;   assign din[1] = arr_data1;
    assign din[2] = arr_data2;   assign din[3] = arr_data3;
    assign win[0] = arr_weight0; assign win[1] = arr_weight1;
    assign win[2] = arr_weight2; assign win[3] = arr_weight3;
    assign arr_result = acc[arr_out_sel[3:2]][arr_out_sel[1:0]];

    always @(posedge clk or negedge arr_rst_n) begin
        if (!arr_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int d = 0; d < 3; d++) begin
                    ska[i][d] <= '0;
                    skb[i][d] <= '0;
                end
                for (int j = 0; j < 4; j++) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end
            end
        end else if (arr_en) begin
            for (int i = 0; i < 4; i++) begin
                ska[i][0] <= din[i]; ska[i][1] <= ska[i][0]; ska[i][2] <= ska[i][1];
                skb[i][0] <= win[i]; skb[i][1] <= skb[i][0]; skb[i][2] <= skb[i][1];
                for (int j = 0; j < 4; j++)
                    acc[i][j] <= acc[i][j] + 32'(pa[i][j]) * 32'(pb[i][j]);
                for (int j = 1; j < 4; j++) begin
                    pa[i][j] <= pa[i][j-1];
                    pb[j][i] <= pb[j-1][i];
                end
            end
            pa[0][0] <= din[0];    pa[1][0] <= ska[1][0];
            pa[2][0] <= ska[2][1]; pa[3][0] <= ska[3][2];
            pb[0][0] <= win[0];    pb[0][1] <= skb[1][0];
            pb[0][2] <= skb[2][1]; pb[0][3] <= skb[3][2];
        end
    end

    // ---------------- checking infrastructure ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    logic [7:0]  ja[256][4];
    logic [7:0]  jb[256][4];
    int          rmode = 0;
    int          rcyc  = 0;
    int          done_cnt = 0;
    int          lat_cnt = 0, lat_meas = -1;
    bit          lat_run = 0;
    bit          exp_done = 0, hold_chk = 0;
    logic [3:0]  h_idx;
    logic [31:0] h_data;

    always @(posedge clk) begin
        #1;
        rcyc++;
        case (rmode)
            1: res_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
            2: res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_done = 0;
            hold_chk = 0;
            lat_run  = 0;
        end else begin
            if (lat_run) begin
                lat_cnt++;
                if (res_valid) begin
                    lat_meas = lat_cnt;
                    lat_run  = 0;
                end
            end
            if (start && !busy) begin
                lat_run = 1;
                lat_cnt = 0;
            end
            if (done || exp_done) begin
                chk("done_pulse", 64'(done), 64'(exp_done));
                if (done) done_cnt++;
            end
            exp_done = res_valid && res_ready && res_last;
            if (hold_chk) begin
                chk("hold_idx", 64'(res_idx), 64'(h_idx));
                chk("hold_data", 64'(res_data), 64'(h_data));
            end
            hold_chk = res_valid && !res_ready;
            h_idx    = res_idx;
            h_data   = res_data;
            if (res_valid && res_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 64'(res_idx), 64'(99));
                end else begin
                    e = sbq.pop_front();
                    chk("res_idx", 64'(res_idx), 64'(e.idx));
                    chk("res_data", 64'(res_data), 64'(e.data));
                    chk("res_last", 64'(res_last), 64'(e.idx == 15));
                end
            end
            if (op_ready) begin
                chk("arr_en_feed", 64'(arr_en), 64'(op_valid));
                if (op_valid) begin
                    chk("lane_a0", 64'(arr_data0), 64'(op_a[7:0]));
                    chk("lane_b3", 64'(arr_weight3), 64'(op_b[31:24]));
                end
            end else if (res_valid) begin
                chk("arr_en_read", 64'(arr_en), 64'(0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic fill_const(input int k, input int av, input int bv);
        for (int t = 0; t < k; t++)
            for (int i = 0; i < 4; i++) begin
                ja[t][i] = 8'(av);
                jb[t][i] = 8'(bv);
            end
    endtask

    task automatic fill_ident();
        for (int t = 0; t < 4; t++)
            for (int i = 0; i < 4; i++) begin
                ja[t][i] = (t == i) ? 8'd1 : 8'd0;
                jb[t][i] = 8'(t * 4 + i + 1);
            end
    endtask

    task automatic push_expected(input int k);
        exp_t x;
        for (int idx = 0; idx < 16; idx++) begin
            x.idx  = idx;
            x.data = 0;
            for (int t = 0; t < k; t++)
                x.data += 32'(ja[t][idx / 4]) * 32'(jb[t][idx % 4]);
            sbq.push_back(x);
        end
    endtask

    task automatic issue_start(input int k);
        cfg_k = 8'(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int k, input int smode, input bit poke);
        int to;
        int gap;
        for (int b = 0; b < k; b++) begin
            op_a     = {ja[b][3], ja[b][2], ja[b][1], ja[b][0]};
            op_b     = {jb[b][3], jb[b][2], jb[b][1], jb[b][0]};
            op_valid = 1'b1;
            start    = poke && (b == 1);
            to = 0;
            do begin
                @(negedge clk);
                to++;
            end while (!op_ready && to < 100);
            if (!op_ready) chk("op_ready_timeout", 64'(0), 64'(1));
            @(posedge clk); #1;
            start = 1'b0;
            gap = 0;
            if (smode == 1 && (b == 0 || b == 2)) gap = 3;
            if (smode == 2) gap = int'($urandom_range(0, 2));
            if (gap > 0) begin
                op_valid = 1'b0;
                op_a = '0;
                op_b = '0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        op_valid = 1'b0;
        op_a = '0;
        op_b = '0;
    endtask

    task automatic run_job(input int k, input int smode, input int rm, input bit poke, input bit chk_lat);
        int d0;
        int to;
        rmode    = rm;
        d0       = done_cnt;
        lat_meas = -1;
        push_expected(k);
        issue_start(k);
        feed(k, smode, poke);
        if (poke) begin
            to = 0;
            while (!res_valid && to < 200) begin
                @(negedge clk);
                to++;
            end
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        to = 0;
        while (done_cnt == d0 && to < 1000) begin
            @(posedge clk);
            to++;
        end
        #1;
        chk("job_done_count", 64'(done_cnt - d0), 64'(1));
        chk("sb_drained", 64'(sbq.size()), 64'(0));
        if (chk_lat) chk("start_to_valid", 64'(lat_meas), 64'(k + 9));
        sbq.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_k = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_op_ready", 64'(op_ready), 64'(0));
        chk("rst_arr_en", 64'(arr_en), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_res_last", 64'(res_last), 64'(0));
        chk("rst_res_idx", 64'(res_idx), 64'(0));
        chk("rst_out_sel", 64'(arr_out_sel), 64'(0));
        chk("rst_arr_rst_n", 64'(arr_rst_n), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_arr_rst_n", 64'(arr_rst_n), 64'(1));

        fill_const(4, 1, 2);  run_job(4, 0, 0, 0, 1);
        fill_ident();         run_job(4, 0, 0, 0, 1);
        fill_ident();         run_job(4, 1, 0, 0, 0);
        fill_ident();         run_job(4, 0, 1, 0, 0);
        fill_const(4, 1, 2);  run_job(4, 0, 0, 1, 0);
        fill_const(4, 5, 5);  run_job(0, 0, 0, 0, 1);
        fill_const(3, 1, 1);  run_job(3, 0, 0, 0, 1);

        begin : reset_mid_flush
            int d0;
            d0 = done_cnt;
            rmode = 0;
            fill_const(4, 1, 1);
            issue_start(4);
            feed(4, 0, 0);
            repeat (3) @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk("midrst_arr_rst_n", 64'(arr_rst_n), 64'(0));
            chk("midrst_busy", 64'(busy), 64'(0));
            chk("midrst_arr_en", 64'(arr_en), 64'(0));
            chk("midrst_res_valid", 64'(res_valid), 64'(0));
            chk("midrst_op_ready", 64'(op_ready), 64'(0));
            chk("midrst_res_idx", 64'(res_idx), 64'(0));
            chk("midrst_done", 64'(done), 64'(0));
            @(negedge clk);
            rst = 1'b0;
            repeat (30) @(posedge clk);
            #1;
            chk("midrst_no_done", 64'(done_cnt - d0), 64'(0));
            chk("midrst_idle", 64'(busy), 64'(0));
        end

        fill_const(2, 1, 1);  run_job(2, 0, 0, 0, 1);

        for (int n = 0; n < 6; n++) begin
            int k;
            k = int'($urandom_range(1, 20));
            for (int t = 0; t < k; t++)
                for (int i = 0; i < 4; i++) begin
                    ja[t][i] = 8'($urandom);
                    jb[t][i] = 8'($urandom);
                end
            run_job(k, 2, 2, 1'(n % 2), 0);
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
